// File: rtl/ps2_rx_framer_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame geometry, FSM state encoding and the odd-parity helper live here.
package ps2_pkg;
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{p, d};
    endfunction
endpackage

// File: rtl/ps2_rx_framer_if.sv
// Received-byte stream: valid/ready handshake between the framer FIFO and its consumer.
interface ps2_rx_framer_if;
    import ps2_pkg::*;
    logic [PS2_DATA_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_rx_framer_clk_filter.sv
// PS/2 clock synchroniser and glitch filter; emits registered fall and edge pulses
// in the same cycle the filtered level changes.
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    output logic clk_flt,
    output logic clk_fall,
    output logic clk_edge
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   clk_s;

    assign clk_s = sync[SYNC_STAGES-1];

    // cnt tracks how many consecutive samples have disagreed with the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '1;
            clk_flt  <= 1'b1;
            clk_fall <= 1'b0;
            clk_edge <= 1'b0;
            cnt      <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], ps2_clk};
            clk_fall <= 1'b0;
            clk_edge <= 1'b0;
            if (clk_s == clk_flt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_flt  <= clk_s;
                cnt      <= '0;
                clk_edge <= 1'b1;
                clk_fall <= ~clk_s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: filtered clock, frame checking, idle timeout
// and a first-word-fall-through receive FIFO with a registered head.
module ps2_rx_framer
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_rx_framer_if.master   rx,
    output logic              parity_err_strb,
    output logic              frame_err_strb,
    output logic              overflow_strb,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic [SYNC_STAGES-1:0] data_sync;
    logic                   data_s;
    logic                   clk_lvl_unused;
    logic                   clk_fall;
    logic                   clk_edge;

    ps2_state_e               state;
    logic [BW-1:0]            bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift;
    logic                     par_bit;
    logic [TW-1:0]            to_cnt;
    logic                     timeout;

    logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]              count, eff_cnt;
    logic                     full, pop, push;
    logic                     stop_fall, frame_ok;

    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_sync <= '1;
        else        data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .clk_flt  (clk_lvl_unused),
        .clk_fall (clk_fall),
        .clk_edge (clk_edge)
    );

    // Idle timer: only runs mid-frame, restarted by any filtered clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            to_cnt <= '0;
        else if (state == ST_IDLE || clk_edge) to_cnt <= '0;
        else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);
    end

    assign timeout   = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
    assign stop_fall = clk_fall && (state == ST_STOP) && !timeout;
    assign frame_ok  = stop_fall && data_s && odd_parity_ok(shift, par_bit);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = rx.rx_valid && rx.rx_ready;
    assign push      = frame_ok && !(full && !pop);

    // Timeout wins over a fall pulse landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            bit_cnt         <= '0;
            shift           <= '0;
            par_bit         <= 1'b0;
            parity_err_strb <= 1'b0;
            frame_err_strb  <= 1'b0;
            overflow_strb   <= 1'b0;
        end else begin
            frame_err_strb  <= timeout
                             || (clk_fall && state == ST_IDLE && data_s)
                             || (stop_fall && !data_s);
            parity_err_strb <= stop_fall && data_s && !odd_parity_ok(shift, par_bit);
            overflow_strb   <= frame_ok && full && !pop;
            if (timeout) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (clk_fall) begin
                case (state)
                    ST_IDLE: if (!data_s) begin
                        state   <= ST_DATA;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        shift   <= {data_s, shift[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    assign eff_cnt = count - (AW+1)'(pop);
    assign rd_nxt  = rd_ptr + AW'(pop);

    // Head register mirrors the entry at the post-update read pointer; a push into
    // an otherwise-empty FIFO bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx.rx_valid <= 1'b0;
            rx.rx_data  <= '0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_nxt;
            count       <= eff_cnt + (AW+1)'(push);
            rx.rx_valid <= (eff_cnt != '0) || push;
            if (eff_cnt != '0)  rx.rx_data <= mem[rd_nxt];
            else if (push)      rx.rx_data <= shift;
        end
    end
endmodule

// File: tb/tb_ps2_rx_framer.sv
// Self-checking bench for ps2_rx_framer: vector table, hand-written corner
// sequences and a randomized run checked against a frame-level reference model.
module tb_ps2_rx_framer;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HP    = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic perr, ferr, ovf, busy;

    ps2_rx_framer_if rx_if();

    always #5 clk = ~clk;

    ps2_rx_framer #(
        .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx(rx_if.master),
        .parity_err_strb(perr), .frame_err_strb(ferr), .overflow_strb(ovf), .busy(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int vcount = 0, first_valid_cyc = 0, ferr_cyc = 0;
    int last_fall_cyc = 0, last_rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic rnd_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
        if (rx_if.rx_valid) begin
            vcount++;
            if (!prev_valid) first_valid_cyc = cyc;
        end
        prev_valid = rx_if.rx_valid;
        if (perr) n_perr++;
        if (ovf)  n_ovf++;
        if (ferr) begin n_ferr++; ferr_cyc = cyc; end
        if (int'(perr) + int'(ferr) + int'(ovf) > 1) begin
            errors++;
            $display("FAIL strobe_mutex: p=%0b f=%0b o=%0b at cycle %0d, required at most one", perr, ferr, ovf, cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_en) rx_if.rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        tick(HP/2);
        ps2_clk = 1'b0; last_fall_cyc = cyc;
        tick(HP);
        ps2_clk = 1'b1; last_rise_cyc = cyc;
        if (glitch) begin
            tick(1);
            ps2_clk = 1'b0; tick(FILT-1);
            ps2_clk = 1'b1; tick(HP/2 - FILT);
        end else begin
            tick(HP/2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_bit);
        ps2_data = 1'b1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         kind;   // 0 byte delivered, 1 parity error, 2 frame error
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic [7:0] exp_q[$];
        int p0, f0, o0, ovf4, exp_p, exp_f, kind;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1};
        tbl[2] = '{8'hF0, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 0};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 0};
        tbl[5] = '{8'hA5, 1'b0, 1'b1, 1};
        tbl[6] = '{8'h3C, 1'b1, 1'b0, 2};
        tbl[7] = '{8'h80, 1'b0, 1'b1, 0};

        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(rx_if.rx_valid), 0);
        chk("rst_data", int'(rx_if.rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'(perr) + int'(ferr) + int'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_strobes", n_perr + n_ferr + n_ovf, 0);

        // Single good frame: one-cycle valid, N+1 after the filtered stop fall.
        vcount = 0; got_q.delete();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        tick(20);
        chk("t1_valid_len", vcount, 1);
        chk("t1_latency", first_valid_cyc - last_fall_cyc, SYNC + FILT + 1);
        chk("t1_data", got_q.size() == 1 ? int'(got_q[0]) : -1, 8'h1C);
        chk("t1_strobes", n_perr + n_ferr + n_ovf, 0);

        foreach (tbl[i]) begin
            p0 = n_perr; f0 = n_ferr; o0 = n_ovf; got_q.delete();
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 11, -1);
            tick(20);
            if (got_q.size() == 1 && n_perr == p0 && n_ferr == f0 && n_ovf == o0) kind = 0;
            else if (got_q.size() == 0 && n_perr == p0 + 1 && n_ferr == f0 && n_ovf == o0) kind = 1;
            else if (got_q.size() == 0 && n_perr == p0 && n_ferr == f0 + 1 && n_ovf == o0) kind = 2;
            else kind = 9;
            chk($sformatf("vec%0d_kind", i), kind, tbl[i].kind);
            if (tbl[i].kind == 0) chk($sformatf("vec%0d_data", i), kind == 0 ? int'(got_q[0]) : -1, int'(tbl[i].d));
        end

        // Truncated frame: timeout abort, then recovery.
        f0 = n_ferr; got_q.delete();
        send_frame(8'h5A, 1'b1, 1'b1, 6, -1);
        chk("t3_busy_mid", int'(busy), 1);
        for (int k = 0; k < TO + 50 && n_ferr == f0; k++) tick(1);
        chk("t3_ferr_count", n_ferr - f0, 1);
        chk("t3_timeout_cyc", ferr_cyc - last_rise_cyc, SYNC + FILT + 2 + TO);
        chk("t3_busy_after", int'(busy), 0);
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        tick(20);
        chk("t3_recover", got_q.size() == 1 ? int'(got_q[0]) : -1, 8'h5A);

        // Overflow: five good frames into a four-entry FIFO with no consumer.
        rx_if.rx_ready = 1'b0; got_q.delete();
        o0 = n_ovf; p0 = n_perr; f0 = n_ferr; ovf4 = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) ovf4 = n_ovf - o0;
            send_frame(8'(i), good_par(8'(i)), 1'b1, 11, -1);
            tick(20);
        end
        chk("t4_no_ovf_first4", ovf4, 0);
        chk("t4_ovf_count", n_ovf - o0, 1);
        chk("t4_other_strobes", (n_perr - p0) + (n_ferr - f0), 0);
        chk("t4_valid_held", int'(rx_if.rx_valid), 1);
        rx_if.rx_ready = 1'b1;
        tick(10);
        chk("t4_pop_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_pop%0d", i), i < got_q.size() ? int'(got_q[i]) : -1, i + 1);
        chk("t4_drained", int'(rx_if.rx_valid), 0);

        // Short clock glitches in IDLE and mid-frame are filtered out.
        p0 = n_perr; f0 = n_ferr; o0 = n_ovf; got_q.delete();
        ps2_clk = 1'b0; tick(FILT-1);
        ps2_clk = 1'b1; tick(10);
        chk("t5_idle_busy", int'(busy), 0);
        send_frame(8'h33, 1'b1, 1'b1, 11, 4);
        tick(20);
        chk("t5_data", got_q.size() == 1 ? int'(got_q[0]) : -1, 8'h33);
        chk("t5_strobes", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);

        // Reset mid-frame discards the partial frame silently.
        p0 = n_perr; f0 = n_ferr; o0 = n_ovf; got_q.delete();
        send_frame(8'h7E, 1'b1, 1'b1, 5, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_valid", int'(rx_if.rx_valid), 0);
        chk("t6_rst_data", int'(rx_if.rx_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(10);
        send_frame(8'h7E, 1'b1, 1'b1, 11, -1);
        tick(20);
        chk("t6_count", got_q.size(), 1);
        chk("t6_data", got_q.size() == 1 ? int'(got_q[0]) : -1, 8'h7E);
        chk("t6_strobes", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);

        // Randomized frames with a jittery consumer against the frame-level model.
        p0 = n_perr; f0 = n_ferr; got_q.delete(); exp_p = 0; exp_f = 0;
        rnd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic bad_p, bad_s;
            d = 8'($urandom);
            bad_p = ($urandom_range(0, 3) == 0);
            bad_s = ($urandom_range(0, 7) == 0);
            if (bad_s)      exp_f++;
            else if (bad_p) exp_p++;
            else            exp_q.push_back(d);
            send_frame(d, good_par(d) ^ bad_p, !bad_s, 11, -1);
            tick($urandom_range(5, 30));
        end
        rnd_en = 1'b0;
        rx_if.rx_ready = 1'b1;
        tick(20);
        chk("rnd_perr", n_perr - p0, exp_p);
        chk("rnd_ferr", n_ferr - f0, exp_f);
        chk("rnd_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("rnd_byte%0d", i), i < got_q.size() ? int'(got_q[i]) : -1, int'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
